// File: rtl/arduino_gpio_debounce_if.sv
// arduino_gpio_debounce_if: pin/level bundle between the Arduino header and the
// GPIO input path.
//   pin_in   : raw header pin levels (asynchronous to clk)
//   filt_out : debounced, registered pin levels
//   change   : one-cycle strobe per bit on each accepted level update
// Modports: master drives pins and observes results; slave is the debouncer.
interface arduino_gpio_debounce_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] pin_in;
  logic [WIDTH-1:0] filt_out;
  logic [WIDTH-1:0] change;

  modport master (output pin_in, input filt_out, input change);
  modport slave  (input pin_in, output filt_out, output change);
endinterface

// File: rtl/arduino_gpio_debounce.sv
// arduino_gpio_debounce: two-flop synchroniser plus tick-sampled debounce for
// each Arduino header pin. A new level is accepted after STABLE_CNT
// consecutive prescaler ticks that all disagree with the current output.
// Ports:
//   clk      : system clock
//   reset_n  : synchronous, active-low reset
//   bus      : arduino_gpio_debounce_if.slave (pin_in in; filt_out, change out)
// Optional feature macro: ARDUINO_DEBOUNCE_CHANGE_EN
//   defined   -> registered per-bit change strobes
//   undefined -> change tied to zero, no strobe flops
module arduino_gpio_debounce #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned PRESCALE   = 500,
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  arduino_gpio_debounce_if.slave    bus
);

  localparam int unsigned CNT_W = $clog2(STABLE_CNT + 1);
  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [WIDTH-1:0]             sync1_q;
  logic [WIDTH-1:0]             sync2_q;
  logic [PRE_W-1:0]             pre_q;
  logic                         tick;
  logic [WIDTH-1:0][CNT_W-1:0]  cnt_q;
  logic [WIDTH-1:0][CNT_W-1:0]  cnt_d;
  logic [WIDTH-1:0]             filt_q;
  logic [WIDTH-1:0]             filt_d;

  // Synchroniser and sample-tick prescaler
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      pre_q   <= '0;
    end else begin
      sync1_q <= bus.pin_in;
      sync2_q <= sync1_q;
      pre_q   <= tick ? '0 : pre_q + PRE_W'(1);
    end
  end

  assign tick = (pre_q == PRE_W'(PRESCALE - 1));

`ifdef ARDUINO_DEBOUNCE_CHANGE_EN
  logic [WIDTH-1:0] chg_q;
  logic [WIDTH-1:0] chg_d;
`endif

  // Per-channel qualification; a return to the current level restarts the count
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
`ifdef ARDUINO_DEBOUNCE_CHANGE_EN
    chg_d  = '0;
`endif
    if (tick) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_W'(STABLE_CNT - 1)) begin
          filt_d[i] = sync2_q[i];
          cnt_d[i]  = '0;
`ifdef ARDUINO_DEBOUNCE_CHANGE_EN
          chg_d[i]  = 1'b1;
`endif
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounce state and outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      filt_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

`ifdef ARDUINO_DEBOUNCE_CHANGE_EN
  // Strobe register; cleared on every cycle without an update
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      chg_q <= '0;
    end else begin
      chg_q <= chg_d;
    end
  end

  assign bus.change = chg_q;
`else
  assign bus.change = '0;
`endif

  assign bus.filt_out = filt_q;

endmodule

// File: tb/tb_arduino_gpio_debounce.sv
// tb_arduino_gpio_debounce: directed bench for arduino_gpio_debounce with
// PRESCALE = 4, STABLE_CNT = 3, WIDTH = 16. Cycle numbers count rising edges
// after the reset release; ticks fall on cycles 4, 8, 12, ...
module tb_arduino_gpio_debounce;

  localparam int unsigned WIDTH = 16;
`ifdef ARDUINO_DEBOUNCE_CHANGE_EN
  localparam bit CHG_EN = 1'b1;
`else
  localparam bit CHG_EN = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  int   cyc;

  arduino_gpio_debounce_if #(.WIDTH(WIDTH)) bus ();

  arduino_gpio_debounce #(
    .WIDTH      (WIDTH),
    .PRESCALE   (4),
    .STABLE_CNT (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; sample and drive 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Hold reset for n edges with pins at pre_pins, then release with post_pins
  task automatic do_reset(input string tag, input logic [15:0] pre_pins,
                          input logic [15:0] post_pins, input int n);
    reset_n    = 1'b0;
    bus.pin_in = pre_pins;
    for (int k = 0; k < n; k++) begin
      step();
      chk({tag, "_rst_filt"}, 32'(bus.filt_out), 32'h0);
      chk({tag, "_rst_chg"},  32'(bus.change),   32'h0);
    end
    reset_n    = 1'b1;
    bus.pin_in = post_pins;
    cyc        = 0;
  endtask

  // Observe n edges: first filt transition cycle/value, change at that cycle,
  // number of filt transitions and number of cycles with any change bit set
  task automatic watch(input int n, output int first_cyc, output logic [15:0] first_filt,
                       output logic [15:0] first_chg, output int n_trans, output int n_strobe);
    logic [15:0] prev;
    prev       = bus.filt_out;
    first_cyc  = 0;
    first_filt = '0;
    first_chg  = '0;
    n_trans    = 0;
    n_strobe   = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if (bus.change != 16'h0) n_strobe++;
      if (bus.filt_out != prev) begin
        n_trans++;
        if (first_cyc == 0) begin
          first_cyc  = cyc;
          first_filt = bus.filt_out;
          first_chg  = bus.change;
        end
      end
      prev = bus.filt_out;
    end
  endtask

  int          fc;
  logic [15:0] ff;
  logic [15:0] fch;
  int          nt;
  int          ns;

  initial begin
    checks     = 0;
    errors     = 0;
    cyc        = 0;
    reset_n    = 1'b0;
    bus.pin_in = 16'h0;

    // 1: reset with all pins high, then qualification of 0->1 on every bit
    do_reset("s1", 16'hFFFF, 16'hFFFF, 3);
    watch(16, fc, ff, fch, nt, ns);
    chk("s1_cycle",   32'(fc),  32'd12);
    chk("s1_filt",    32'(ff),  32'hFFFF);
    chk("s1_chg",     32'(fch), CHG_EN ? 32'hFFFF : 32'h0);
    chk("s1_ntrans",  32'(nt),  32'd1);
    chk("s1_nstrobe", 32'(ns),  CHG_EN ? 32'd1 : 32'd0);

    // 2: single-bit step on pin 0
    do_reset("s2", 16'h0000, 16'h0001, 1);
    watch(14, fc, ff, fch, nt, ns);
    chk("s2_cycle",   32'(fc),  32'd12);
    chk("s2_filt",    32'(ff),  32'h0001);
    chk("s2_chg",     32'(fch), CHG_EN ? 32'h0001 : 32'h0);
    chk("s2_ntrans",  32'(nt),  32'd1);
    chk("s2_nstrobe", 32'(ns),  CHG_EN ? 32'd1 : 32'd0);

    // 3: 6-cycle glitch on pin 5 is rejected, a held level is accepted
    bus.pin_in = 16'h0021;
    watch(6, fc, ff, fch, nt, ns);
    chk("s3_glitch_ntrans_a",  32'(nt), 32'd0);
    chk("s3_glitch_nstrobe_a", 32'(ns), 32'd0);
    bus.pin_in = 16'h0001;
    watch(10, fc, ff, fch, nt, ns);
    chk("s3_glitch_ntrans_b",  32'(nt), 32'd0);
    chk("s3_glitch_nstrobe_b", 32'(ns), 32'd0);
    chk("s3_glitch_filt",      32'(bus.filt_out), 32'h0001);
    bus.pin_in = 16'h0021;
    watch(20, fc, ff, fch, nt, ns);
    chk("s3_hold_cycle",   32'(fc),  32'd44);
    chk("s3_hold_filt",    32'(ff),  32'h0021);
    chk("s3_hold_chg",     32'(fch), CHG_EN ? 32'h0020 : 32'h0);
    chk("s3_hold_ntrans",  32'(nt),  32'd1);
    chk("s3_hold_nstrobe", 32'(ns),  CHG_EN ? 32'd1 : 32'd0);

    // 4: several bits update on one edge
    do_reset("s4", 16'h0000, 16'hA5A5, 1);
    watch(16, fc, ff, fch, nt, ns);
    chk("s4_cycle",   32'(fc),  32'd12);
    chk("s4_filt",    32'(ff),  32'hA5A5);
    chk("s4_chg",     32'(fch), CHG_EN ? 32'hA5A5 : 32'h0);
    chk("s4_ntrans",  32'(nt),  32'd1);
    chk("s4_nstrobe", 32'(ns),  CHG_EN ? 32'd1 : 32'd0);

    // 5: reset after two mismatching ticks discards the partial count
    do_reset("s5a", 16'h0000, 16'h0008, 1);
    watch(9, fc, ff, fch, nt, ns);
    chk("s5_pre_ntrans", 32'(nt), 32'd0);
    chk("s5_pre_filt",   32'(bus.filt_out), 32'h0);
    do_reset("s5b", 16'h0008, 16'h0008, 1);
    watch(16, fc, ff, fch, nt, ns);
    chk("s5_cycle",   32'(fc),  32'd12);
    chk("s5_filt",    32'(ff),  32'h0008);
    chk("s5_chg",     32'(fch), CHG_EN ? 32'h0008 : 32'h0);
    chk("s5_ntrans",  32'(nt),  32'd1);
    chk("s5_nstrobe", 32'(ns),  CHG_EN ? 32'd1 : 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
